window_ctrl: RTL
================

Name: window_ctrl

Overview:
- Sequences the 5-row line-buffer window (140 x 16-bit shift register, 5 tap outputs, tap spacing selected by its `state` input: 28-wide or 12-wide frame).
- Accepts one frame of pixels from the upstream buffer over a valid/ready handshake and drives the window's shift-enable, data and layer-select inputs.
- After the last pixel, flushes the window.
- Flags which tap columns are valid and which complete a 5x5 window, with the output-pixel coordinates.
- Sits between the feature-map buffer and the 5x5 binary-conv column accumulator.

Parameters:
- DW, 16, pixel width
- K, 5, kernel size (rows and columns)
- W0, 28, frame width/height when layer = 0
- W1, 12, frame width/height when layer = 1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  start-of-frame pulse; sampled only in IDLE
- cfg_layer  in  1  0 = 28x28 frame, 1 = 12x12 frame; latched on accepted go
- in_valid  in  1  upstream pixel valid
- in_data  in  DW  upstream pixel, raster order
- in_ready  out  1  pixel accepted when in_valid && in_ready
- win_shift  out  1  to window start (shift enable)
- win_din  out  DW  to window din
- win_state  out  1  to window state (latched layer)
- col_valid  out  1  window taps hold a complete 5-row column
- col_ready  in  1  downstream consumed the column
- win_valid  out  1  col_valid, and this column completes a 5x5 window
- out_row  out  5  output-pixel row, 0..W-5; meaningful when win_valid
- out_col  out  5  output-pixel column, 0..W-5; meaningful when win_valid
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- W = latched layer ? W1 : W0.
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Reset mid-frame aborts immediately. Window contents are not cleared and need not be: stale data never reaches a flagged column.

FSM states:
- IDLE: on go, latch cfg_layer into win_state, clear counters, go to RUN. go in any other state is ignored.
- RUN: accepts exactly W*W pixels. On acceptance of pixel W*W-1, go to FLUSH.
- FLUSH: issues W-1 further shifts with win_din = 0, then goes to DRAIN.
- DRAIN: waits until col_valid = 0, or col_valid && col_ready. That cycle pulses frame_done, and the FSM returns to IDLE.

Shift and handshake:
- stall = col_valid && !col_ready.
- push = !stall && ((RUN && in_valid) || FLUSH).
- in_ready = RUN && !stall (combinational).
- win_shift = push (combinational). win_din = RUN ? in_data : 0.

Push counters and tap position:
- k counts pushes issued (0..W*W+W-2; 10 bits).
- The window taps after push k hold column position p = k-(W-1), rows row(p)-4..row(p).
- p_row and p_col (5 bits each, raster wrap at W) advance on each push with k >= W-1.

Registered outputs (1-cycle latency after the push edge):
- On a push edge with k >= W-1: col_valid <= (p_row >= 4); win_valid <= (p_row >= 4 && p_col >= 4); out_row <= p_row-4; out_col <= p_col-4. All use pre-increment values.
- On a non-push edge with col_valid && col_ready: col_valid and win_valid clear.
- While stalled, col_valid, win_valid, out_row and out_col hold, and the taps hold.

Per-frame counts:
- W=28: 811 shifts, 672 col_valid, 576 win_valid.
- W=12: 155 shifts, 96 col_valid, 64 win_valid.

Decomposition:
- Shared package `bnn_pkg`: DW, K, W0, W1, the FSM state encoding (IDLE, RUN, FLUSH, DRAIN), and the constant LAYER_L1 = 1'b0 / LAYER_L3 = 1'b1.
- One sub-module, `raster_cnt`: row/column counter with enable, runtime wrap width and clear. It is instantiated for p_row/p_col. k is a plain counter.
- Optional top-level test wrapper `window_seq` instantiates window_ctrl plus the window.

Test Plan:
- layer=1, ramp pixels 0..143, in_valid=1, col_ready=1 -> win_shift high for 155 cycles. First win_valid appears the cycle after the 64th accepted pixel, with out_row=0, out_col=0 and taps {52,40,28,16,4}. The bench counts 96 col_valid and 64 win_valid. frame_done is a single pulse; busy then falls.
- layer=0, ramp 0..783 mod 2^16 -> first win_valid after the 144th pixel, with taps {116,88,60,32,4}. Last win_valid has out_row=23, out_col=23 and taps {783,755,727,699,671}. The bench counts 576 win_valid.
- layer=1 with col_ready held low for 5 cycles at the first col_valid -> in_ready and win_shift stay 0. col_valid, taps and out_row/out_col are stable, no pixel is lost, and the totals match the first scenario.
- layer=1 with in_valid toggling 1/0 every cycle -> win_shift only on accepted beats. Output sequence is identical to the first scenario, stretched in time.
- go pulsed with cfg_layer=0 mid-frame of a layer=1 run -> ignored; win_state stays 1 and the frame completes normally.
- rst_n asserted after 70 pixels, then go with layer=1 and a new ramp -> all outputs 0 during reset. The new frame produces exactly 64 win_valid with correct taps, and no stale column is flagged.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants for the binary-conv front end.
//   DW     : pixel width
//   K      : kernel size (rows and columns)
//   W0/W1  : frame width/height for layer select 0 / 1
//   S_*    : window_ctrl FSM encoding
//   LAYER_*: layer-select encodings driven onto the window's state input
package bnn_pkg;
  localparam int DW = 16;
  localparam int K  = 5;
  localparam int W0 = 28;
  localparam int W1 = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic LAYER_L1 = 1'b0;  // 28x28 frame
  localparam logic LAYER_L3 = 1'b1;  // 12x12 frame
endpackage

// File: rtl/window_ctrl_raster_cnt.sv
// raster_cnt: row/column raster counter with a runtime wrap width.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to (0,0); wins over en
//   en         : advance one position in raster order
//   wrap       : frame width; col wraps at wrap-1, then row advances
//   row, col   : current position
module raster_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [4:0] wrap,
  output logic [4:0] row,
  output logic [4:0] col
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == wrap - 5'd1) begin
        col <= '0;
        row <= (row == wrap - 5'd1) ? 5'd0 : row + 5'd1;
      end else begin
        col <= col + 5'd1;
      end
    end
  end
endmodule

// File: rtl/window_ctrl.sv
// window_ctrl: sequences the 5-row line-buffer window for one frame.
//   go/cfg_layer        : frame start and size select (latched in IDLE)
//   in_valid/in_ready/in_data : raster pixel stream from the feature buffer
//   win_shift/win_din/win_state : drive the window shift register
//   col_valid/col_ready : window taps hold a full 5-row column / consumed
//   win_valid, out_row, out_col : column completes a 5x5, with output coords
//   busy, frame_done    : frame in progress / end-of-frame pulse
module window_ctrl
  import bnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          cfg_layer,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          win_shift,
  output logic [DW-1:0] win_din,
  output logic          win_state,
  output logic          col_valid,
  input  logic          col_ready,
  output logic          win_valid,
  output logic [4:0]    out_row,
  output logic [4:0]    out_col,
  output logic          busy,
  output logic          frame_done
);
  logic [1:0] state;
  logic       layer;
  logic [9:0] k;
  logic [9:0] last_pix, last_push, k_live;
  logic [4:0] wd, p_row, p_col;
  logic       stall, push, tap_live, start;

  assign wd        = (layer == LAYER_L3) ? 5'(W1) : 5'(W0);
  assign last_pix  = (layer == LAYER_L3) ? 10'(W1*W1 - 1) : 10'(W0*W0 - 1);
  assign last_push = (layer == LAYER_L3) ? 10'(W1*W1 + W1 - 2) : 10'(W0*W0 + W0 - 2);
  // The newest tap sits W-1 stages into the window, so the first W-1 pushes
  // only fill the pipe and carry no column position.
  assign k_live    = 10'(wd) - 10'd1;
  assign tap_live  = (k >= k_live);

  assign start      = (state == S_IDLE) && go;
  assign stall      = col_valid && !col_ready;
  assign push       = !stall && (((state == S_RUN) && in_valid) || (state == S_FLUSH));
  assign in_ready   = (state == S_RUN) && !stall;
  assign win_shift  = push;
  assign win_din    = (state == S_RUN) ? in_data : '0;
  assign win_state  = layer;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DRAIN) && (!col_valid || col_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      layer <= LAYER_L1;
      k     <= '0;
    end else begin
      if (start)     k <= '0;
      else if (push) k <= k + 10'd1;
      case (state)
        S_IDLE: if (go) begin
          layer <= cfg_layer;
          state <= S_RUN;
        end
        S_RUN:   if (push && k == last_pix)  state <= S_FLUSH;
        S_FLUSH: if (push && k == last_push) state <= S_DRAIN;
        default: if (!col_valid || col_ready) state <= S_IDLE;
      endcase
    end
  end

  raster_cnt u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (push && tap_live),
    .wrap  (wd),
    .row   (p_row),
    .col   (p_col)
  );

  // Flags describe the taps after this push, so they use the position
  // before the counter advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_valid <= 1'b0;
      win_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (push && tap_live) begin
      col_valid <= (p_row >= 5'(K-1));
      win_valid <= (p_row >= 5'(K-1)) && (p_col >= 5'(K-1));
      out_row   <= p_row - 5'(K-1);
      out_col   <= p_col - 5'(K-1);
    end else if (!push && col_valid && col_ready) begin
      col_valid <= 1'b0;
      win_valid <= 1'b0;
    end
  end
endmodule
